// File: rtl/instr_encoder_if.sv
// Request and imem-write bundle for instr_encoder. The slave side is the encoder.
// With IMEM_PARITY_EN defined, the bundle also carries imem_wpar.
interface instr_encoder_if #(
    parameter int ADDR_W = 8
);
    // Handshake: a request transfers on a rising clk edge where req_valid && req_ready;
    // req_valid carries no obligation to hold, and fields are sampled only at that edge.
    logic              req_valid;
    logic              req_ready;
    logic [2:0]        op_sel;
    logic [4:0]        rs;
    logic [4:0]        rt;
    logic [4:0]        rd;
    logic [15:0]       imm;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic [ADDR_W:0]   count;
    logic              full;
    logic              err;
`ifdef IMEM_PARITY_EN
    logic              imem_wpar;
`endif

    modport slave (
        input  req_valid, op_sel, rs, rt, rd, imm,
        output req_ready, imem_we, imem_addr, imem_wdata, count, full, err
`ifdef IMEM_PARITY_EN
        , output imem_wpar
`endif
    );

    modport master (
        output req_valid, op_sel, rs, rt, rd, imm,
        input  req_ready, imem_we, imem_addr, imem_wdata, count, full, err
`ifdef IMEM_PARITY_EN
        , input imem_wpar
`endif
    );
endinterface

// File: rtl/instr_encoder.sv
// Mnemonic-to-word encoder that streams words into consecutive imem addresses.
// Optional IMEM_PARITY_EN adds a registered even-parity bit beside imem_wdata.
module instr_encoder #(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256,
    parameter int BASE   = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr,
    instr_encoder_if.slave     bus,
    output logic [1:0]         o_dbg_state
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WRITE = 2'd1;
    localparam logic [1:0] S_FULL  = 2'd2;

    localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] BASE_C  = ADDR_W'(BASE);

    logic [1:0]      r_state;
    logic [ADDR_W:0] r_count;
    logic [31:0]     r_word;
    logic            r_err;
`ifdef IMEM_PARITY_EN
    logic            r_par;
`endif

    logic [5:0]      w_op;
    logic            w_rfmt;
    logic            w_legal;
    logic [31:0]     w_enc;
    logic            w_accept;
    logic [ADDR_W:0] w_count_inc;

    // Custom opcode map; op_sel 6 and 7 are illegal and never produce a write.
    always_comb begin
        w_op    = 6'b000000;
        w_rfmt  = 1'b0;
        w_legal = 1'b1;
        case (bus.op_sel)
            3'd0: w_op = 6'b100011;
            3'd1: begin w_op = 6'b100000; w_rfmt = 1'b1; end
            3'd2: begin w_op = 6'b010110; w_rfmt = 1'b1; end
            3'd3: w_op = 6'b001101;
            3'd4: w_op = 6'b011110;
            3'd5: begin w_op = 6'b000110; w_rfmt = 1'b1; end
            default: w_legal = 1'b0;
        endcase
        w_enc = w_rfmt ? {w_op, bus.rs, bus.rt, bus.rd, 11'b0}
                       : {w_op, bus.rs, bus.rt, bus.imm};
    end

    assign bus.req_ready = (r_state == S_IDLE) && !clr;
    assign w_accept      = bus.req_valid && bus.req_ready;
    assign w_count_inc   = r_count + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_count <= '0;
            r_word  <= '0;
            r_err   <= 1'b0;
`ifdef IMEM_PARITY_EN
            r_par   <= 1'b0;
`endif
        end else if (clr) begin
            r_state <= S_IDLE;
            r_count <= '0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        if (w_legal) begin
                            r_word  <= w_enc;
`ifdef IMEM_PARITY_EN
                            r_par   <= ^w_enc;
`endif
                            r_state <= S_WRITE;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                S_WRITE: begin
                    r_count <= w_count_inc;
                    r_state <= (w_count_inc == DEPTH_C) ? S_FULL : S_IDLE;
                end
                S_FULL:  r_state <= S_FULL;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // clr in the write cycle cancels the strobe combinationally.
    assign bus.imem_we    = (r_state == S_WRITE) && !clr;
    assign bus.imem_addr  = BASE_C + r_count[ADDR_W-1:0];
    assign bus.imem_wdata = r_word;
    assign bus.count      = r_count;
    assign bus.full       = (r_count == DEPTH_C);
    assign bus.err        = r_err;
`ifdef IMEM_PARITY_EN
    assign bus.imem_wpar  = r_par;
`endif
    assign o_dbg_state    = r_state;
endmodule

// File: tb/tb_instr_encoder.sv
// Randomized bench for instr_encoder: transaction model feeds an expected-write queue
// that a negedge monitor drains; per-cycle status is compared against the same model.
module tb_instr_encoder;
  localparam int ADDR_W = 2;
  localparam int DEPTH  = 4;
  localparam int BASE   = 2;
  localparam int W      = ADDR_W + 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clr = 1'b0;
  logic [1:0] dbg_state;

  instr_encoder_if #(.ADDR_W(ADDR_W)) bus ();

  instr_encoder #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .BASE(BASE)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .clr(clr),
    .bus(bus.slave),
    .o_dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  logic [W-1:0] exp_q[$];

  // reference model: a pending word, words written, sticky error
  bit m_writing;
  int m_count;
  bit m_err;
  logic [31:0] m_word;

  // expectations for the cycle currently being driven
  bit e_valid = 1'b0;
  bit e_ready, e_we, e_full, e_err;
  int e_count;

  function automatic logic [31:0] ref_encode(int op, int rs, int rt, int rd, int imm);
    int opc[6] = '{'h23, 'h20, 'h16, 'h0D, 'h1E, 'h06};
    bit rfmt = (op == 1) || (op == 2) || (op == 5);
    longint w;
    w = longint'(opc[op]) * 64'h400_0000 + longint'(rs) * 64'h20_0000 + longint'(rt) * 64'h1_0000;
    w = w + (rfmt ? longint'(rd) * 2048 : longint'(imm));
    return w[31:0];
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic apply(bit v, bit c, int op, int rs, int rt, int rd, int imm);
    logic [ADDR_W-1:0] a;
    bus.req_valid = v;
    bus.op_sel = 3'(op);
    bus.rs = 5'(rs);
    bus.rt = 5'(rt);
    bus.rd = 5'(rd);
    bus.imm = 16'(imm);
    clr = c;
    e_ready = !m_writing && (m_count < DEPTH) && !c;
    e_we = m_writing && !c;
    e_count = m_count;
    e_full = (m_count == DEPTH);
    e_err = m_err;
    e_valid = 1'b1;
    if (c) begin
      m_writing = 1'b0;
      m_count = 0;
      m_err = 1'b0;
    end else if (m_writing) begin
      a = ADDR_W'(BASE + m_count);
      exp_q.push_back({a, m_word});
      m_count++;
      m_writing = 1'b0;
    end else if (v && e_ready) begin
      if (op < 6) begin
        m_writing = 1'b1;
        m_word = ref_encode(op, rs, rt, rd, imm);
      end else begin
        m_err = 1'b1;
      end
    end
  endtask

  task automatic cycle(bit v, bit c, int op, int rs, int rt, int rd, int imm);
    @(posedge clk);
    #1;
    apply(v, c, op, rs, rt, rd, imm);
  endtask

  task automatic check_reset_values();
    check("rst_we", bus.imem_we, 0);
    check("rst_addr", bus.imem_addr, BASE);
    check("rst_wdata", bus.imem_wdata, 0);
    check("rst_count", bus.count, 0);
    check("rst_full", bus.full, 0);
    check("rst_err", bus.err, 0);
`ifdef IMEM_PARITY_EN
    check("rst_wpar", bus.imem_wpar, 0);
`endif
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    m_writing = 1'b0;
    m_count = 0;
    m_err = 1'b0;
    apply(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic mid_write_reset();
    @(negedge clk);
    #2;
    e_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check_reset_values();
    release_reset();
  endtask

  // monitor: per-cycle status plus write scoreboard
  always @(negedge clk) begin
    if (rst_n && e_valid) begin
      check("req_ready", bus.req_ready, e_ready);
      check("imem_we", bus.imem_we, e_we);
      check("count", bus.count, e_count);
      check("full", bus.full, e_full);
      check("err", bus.err, e_err);
      if (bus.imem_we) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, expected none", bus.imem_addr, bus.imem_wdata);
        end else begin
          logic [W-1:0] e;
          e = exp_q.pop_front();
          check("imem_addr", bus.imem_addr, e[W-1:32]);
          check("imem_wdata", bus.imem_wdata, e[31:0]);
`ifdef IMEM_PARITY_EN
          check("imem_wpar", bus.imem_wpar, ^e[31:0]);
`endif
        end
      end
    end
  end

  initial begin
    bus.req_valid = 1'b0;
    bus.op_sel = '0;
    bus.rs = '0;
    bus.rt = '0;
    bus.rd = '0;
    bus.imm = '0;
    #12;
    check_reset_values();
    release_reset();

    // ori, then back-to-back srlv / bgezal with valid held high
    cycle(1, 0, 3, 1, 2, 0, 'h00FF);
    cycle(0, 0, 0, 0, 0, 0, 0);
    cycle(1, 0, 5, 3, 4, 5, 0);
    cycle(1, 0, 0, 7, 0, 0, 'hFFFC);
    cycle(1, 0, 0, 7, 0, 0, 'hFFFC);
    cycle(0, 0, 0, 0, 0, 0, 0);
    // illegal op then jmadd of zeros fills the last slot
    cycle(1, 0, 6, 9, 9, 9, 'h1111);
    cycle(0, 0, 0, 0, 0, 0, 0);
    cycle(1, 0, 1, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0);
    // full: further requests are refused until clr
    for (int i = 0; i < 3; i++) cycle(1, 0, 3, i, i, 0, i);
    cycle(1, 1, 3, 1, 1, 0, 1);
    cycle(1, 0, 4, 9, 10, 0, 'h1234);
    cycle(0, 0, 0, 0, 0, 0, 0);
    // clr during the write cycle drops the write
    cycle(1, 0, 2, 1, 1, 1, 0);
    cycle(0, 1, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0);
    // asynchronous reset in the middle of a write cycle
    cycle(1, 0, 3, 5, 6, 0, 'hABCD);
    cycle(0, 0, 0, 0, 0, 0, 0);
    mid_write_reset();

    for (int i = 0; i < 1500; i++) begin
      cycle(($urandom_range(0, 9) < 8), ($urandom_range(0, 24) == 0),
            $urandom_range(0, 7), $urandom_range(0, 31), $urandom_range(0, 31),
            $urandom_range(0, 31), $urandom_range(0, 65535));
    end
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    #1;
    check("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
